// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory responder.
//   mem_state_t : state encoding used by both the fetch and data FSMs
//   LAT_W       : width of the per-channel response latency counters
//   WORD_W      : data word width
package mips_mem_pkg;

    localparam int LAT_W  = 4;
    localparam int WORD_W = 32;

    // One encoding serves both channels. The fetch FSM only uses
    // IDLE/ACK/WAIT/RESP; the data FSM also uses WACK/RACK.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACK  = 3'd1,
        ST_WACK = 3'd2,
        ST_RACK = 3'd3,
        ST_WAIT = 3'd4,
        ST_RESP = 3'd5
    } mem_state_t;

endpackage

// File: rtl/mips_dp_ram.sv
// Word-addressed dual-port RAM backing the responder.
//   clk      in   clock
//   a_en     in   port A read enable (fetch side)
//   a_addr   in   port A word address
//   a_q      out  port A registered read word
//   b_en     in   port B read enable (data side)
//   b_we     in   port B write enable
//   b_addr   in   port B word address
//   b_wdata  in   port B write word
//   b_strb   in   port B byte-lane enables, bit i covers bits [8i+7:8i]
//   b_q      out  port B registered read word
// Both ports are read-first: a read issued on the same edge as a write to
// the same word returns the word as it was before that write. Contents are
// not reset.
module mips_dp_ram
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [WORD_W-1:0] a_q,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WORD_W-1:0] b_wdata,
    input  logic [3:0]        b_strb,
    output logic [WORD_W-1:0] b_q
);

    logic [WORD_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_q <= mem[a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (b_en) begin
            b_q <= mem[b_addr];
        end
        if (b_we) begin
            for (int i = 0; i < 4; i++) begin
                if (b_strb[i]) begin
                    mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core. Serves the
// instruction fetch channel and the data channel from a dual-port RAM,
// with a programmable response latency per channel, and keeps request
// counters for comparison against the core's perf counters.
//   clk, rst          clock; asynchronous active-low reset
//   PC                fetch byte address (bits [1:0] ignored)
//   Inst_Req_Valid    fetch request
//   Inst_Req_Ack      fetch request accepted (1-cycle pulse)
//   Instruction       fetched word (registered)
//   Inst_Valid        Instruction valid
//   Inst_Ack          core takes Instruction
//   Address           data byte address (bits [1:0] ignored)
//   MemWrite          write request (has priority over MemRead)
//   Write_data        lane-aligned write word
//   Write_strb        byte-lane enables
//   MemRead           read request
//   Mem_Req_Ack       data request accepted (1-cycle pulse)
//   Read_data         read word (registered)
//   Read_data_Valid   Read_data valid
//   Read_data_Ack     core takes Read_data
//   cnt_fetch         completed fetch handshakes
//   cnt_load          completed read handshakes
//   cnt_store         accepted writes
//
// Handshake semantics: a request is sampled only while its FSM is IDLE and
// is acknowledged by a one-cycle *_Ack pulse the following cycle; after
// that the request line is ignored. A response is offered with *_Valid
// high and data stable, and it completes on the clock edge where *_Valid
// and the core's ack are both high. Valid then drops for at least one
// cycle, because the core latches on the Valid rising edge.
//
// Latency: valid rises LAT cycles after the ack cycle. The RAM is read on
// the edge that accepts the request, so the word is already available in
// the ack cycle; with LAT=1 the ack cycle captures it and goes straight to
// RESP, otherwise WAIT burns the remaining LAT-1 cycles.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int INST_LAT = 1,
    parameter int DATA_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack,
    output logic [31:0] cnt_fetch,
    output logic [31:0] cnt_load,
    output logic [31:0] cnt_store
);

    // Counter preload: remaining cycles after the ack cycle, minus one.
    localparam logic [LAT_W-1:0] INST_LAT_M1 = LAT_W'(INST_LAT - 1);
    localparam logic [LAT_W-1:0] DATA_LAT_M1 = LAT_W'(DATA_LAT - 1);

    // Address bits above the RAM and the byte offset are deliberately
    // dropped, so addresses alias modulo the RAM size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{PC[31:ADDR_W+2], PC[1:0],
                                Address[31:ADDR_W+2], Address[1:0]};

    // ---------------- RAM ----------------
    logic              ram_a_en;
    logic [WORD_W-1:0] ram_a_q;
    logic              ram_b_en;
    logic              ram_b_we;
    logic [ADDR_W-1:0] ram_b_addr;
    logic [WORD_W-1:0] ram_b_q;

    // ---------------- fetch FSM ----------------
    mem_state_t       f_state;
    mem_state_t       f_next;
    logic [LAT_W-1:0] f_lat;
    logic             f_lat_load;
    logic             f_lat_dec;
    logic             f_capture;
    logic             f_done;

    // The RAM read register on port A doubles as the latched fetch address:
    // it is only enabled on the accepting edge, so it holds the word for the
    // rest of the transaction.
    assign ram_a_en = (f_state == ST_IDLE) && Inst_Req_Valid;

    always_comb begin
        f_next     = f_state;
        f_lat_load = 1'b0;
        f_lat_dec  = 1'b0;
        f_capture  = 1'b0;
        f_done     = 1'b0;
        case (f_state)
            ST_IDLE: begin
                if (Inst_Req_Valid) begin
                    f_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (INST_LAT_M1 == '0) begin
                    f_capture = 1'b1;
                    f_next    = ST_RESP;
                end else begin
                    f_lat_load = 1'b1;
                    f_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (f_lat <= LAT_W'(1)) begin
                    f_capture = 1'b1;
                    f_next    = ST_RESP;
                end else begin
                    f_lat_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (Inst_Ack) begin
                    f_done = 1'b1;
                    f_next = ST_IDLE;
                end
            end
            default: f_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_state     <= ST_IDLE;
            f_lat       <= '0;
            Instruction <= '0;
            cnt_fetch   <= '0;
        end else begin
            f_state <= f_next;
            if (f_lat_load) begin
                f_lat <= INST_LAT_M1;
            end else if (f_lat_dec) begin
                f_lat <= f_lat - 1'b1;
            end
            if (f_capture) begin
                Instruction <= ram_a_q;
            end
            if (f_done) begin
                cnt_fetch <= cnt_fetch + 32'd1;
            end
        end
    end

    assign Inst_Req_Ack = (f_state == ST_ACK);
    assign Inst_Valid   = (f_state == ST_RESP);

    // ---------------- data FSM ----------------
    mem_state_t        d_state;
    mem_state_t        d_next;
    logic [LAT_W-1:0]  d_lat;
    logic              d_lat_load;
    logic              d_lat_dec;
    logic              d_capture;
    logic              d_done;
    logic              d_latch;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic [3:0]        d_strb;

    always_comb begin
        d_next     = d_state;
        d_lat_load = 1'b0;
        d_lat_dec  = 1'b0;
        d_capture  = 1'b0;
        d_done     = 1'b0;
        d_latch    = 1'b0;
        case (d_state)
            ST_IDLE: begin
                if (MemWrite) begin
                    d_latch = 1'b1;
                    d_next  = ST_WACK;
                end else if (MemRead) begin
                    d_latch = 1'b1;
                    d_next  = ST_RACK;
                end
            end
            ST_WACK: begin
                d_next = ST_IDLE;
            end
            ST_RACK: begin
                if (DATA_LAT_M1 == '0) begin
                    d_capture = 1'b1;
                    d_next    = ST_RESP;
                end else begin
                    d_lat_load = 1'b1;
                    d_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (d_lat <= LAT_W'(1)) begin
                    d_capture = 1'b1;
                    d_next    = ST_RESP;
                end else begin
                    d_lat_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (Read_data_Ack) begin
                    d_done = 1'b1;
                    d_next = ST_IDLE;
                end
            end
            default: d_next = ST_IDLE;
        endcase
    end

    // Read on the accepting edge (like the fetch side); the write goes out
    // at the end of WACK from the latched address/data/strobe. Gating the
    // write with the registered state means an asynchronous reset in WACK
    // cancels the write.
    assign ram_b_en   = (d_state == ST_IDLE) && MemRead && !MemWrite;
    assign ram_b_we   = (d_state == ST_WACK);
    assign ram_b_addr = (d_state == ST_IDLE) ? Address[ADDR_W+1:2] : d_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_state   <= ST_IDLE;
            d_lat     <= '0;
            d_addr    <= '0;
            d_wdata   <= '0;
            d_strb    <= '0;
            Read_data <= '0;
            cnt_load  <= '0;
            cnt_store <= '0;
        end else begin
            d_state <= d_next;
            if (d_latch) begin
                d_addr  <= Address[ADDR_W+1:2];
                d_wdata <= Write_data;
                d_strb  <= Write_strb;
            end
            if (d_lat_load) begin
                d_lat <= DATA_LAT_M1;
            end else if (d_lat_dec) begin
                d_lat <= d_lat - 1'b1;
            end
            if (d_capture) begin
                Read_data <= ram_b_q;
            end
            if (d_done) begin
                cnt_load <= cnt_load + 32'd1;
            end
            if (d_state == ST_WACK) begin
                cnt_store <= cnt_store + 32'd1;
            end
        end
    end

    assign Mem_Req_Ack     = (d_state == ST_WACK) || (d_state == ST_RACK);
    assign Read_data_Valid = (d_state == ST_RESP);

    mips_dp_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk     (clk),
        .a_en    (ram_a_en),
        .a_addr  (PC[ADDR_W+1:2]),
        .a_q     (ram_a_q),
        .b_en    (ram_b_en),
        .b_we    (ram_b_we),
        .b_addr  (ram_b_addr),
        .b_wdata (d_wdata),
        .b_strb  (d_strb),
        .b_q     (ram_b_q)
    );

endmodule
